ped_signal_ctrl: RTL and testbench
==================================

Name: ped_signal_ctrl

Overview:
- Downstream consumer of the intersection light state machine's 2-bit `light` code.
- Drives the pedestrian WALK / DON'T WALK head for the crossing that runs parallel to the red phase.
- Latches push-button requests and grants a timed WALK, then a flashing DON'T WALK clearance, on entry to red.
- Aborts to a safe state if red ends early or an illegal light code appears.

Parameters:
- WALK_TICKS, 8, number of `tick` pulses WALK stays lit; legal range 1..255.
- CLEAR_TICKS, 6, number of `tick` pulses of flashing DON'T WALK clearance; legal range 1..255.
- RECALL, 0, when 1 WALK is granted on every red entry, whether or not a request is pending.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle timebase enable, nominally 1 Hz.
- light  input  2  vehicle light code: red=2'b01, green=2'b10, yellow=2'b11, 2'b00 illegal.
- ped_button  input  1  push button, already synchronised and debounced upstream; level-sensitive.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DON'T WALK lamp; blinks during the clearance interval.
- request_pending  output  1  a request is latched and not yet served.
- overrun  output  1  sticky: red ended while WALK or CLEAR was active.
- fault  output  1  sticky: illegal light code 2'b00 was seen.
- countdown  output  8  remaining clearance ticks; present only with PED_COUNTDOWN_EN.

Behaviour:
- Reset (async assert, sync release) sets outputs and internal registers to:
  - walk=0, dont_walk=1, request_pending=0, overrun=0, fault=0, countdown=0.
  - state=IDLE, prev_light=red, phase counter=0, flash=1.
- Because prev_light resets to red, a red present at reset release does not count as a red entry.
- red_entry is true in a cycle where light==red and prev_light!=red. prev_light samples light on every clock.
- All outputs are registered: a transition decided in cycle t is visible after the edge at the end of t.
- States:
  - IDLE: walk=0, dont_walk=1. On red_entry with (request_pending or RECALL) and fault=0: load counter=WALK_TICKS, clear request_pending, go to WALK. On red_entry without a request: go to HOLD.
  - WALK: walk=1, dont_walk=0. On tick, counter decrements. A tick when counter==1 loads counter=CLEAR_TICKS, sets flash=1 and goes to CLEAR. WALK therefore spans exactly WALK_TICKS ticks.
  - CLEAR: walk=0, dont_walk=flash. flash toggles on every tick and the counter decrements. A tick when counter==1 goes to HOLD.
  - HOLD: walk=0, dont_walk=1. Leaves to IDLE when light!=red.
- Abort rule: in WALK or CLEAR, if light!=red, go to IDLE next edge, set overrun, and force dont_walk=1. Abort has priority over counter expiry in the same cycle.
- Illegal code: light==2'b00 in any state sets fault and goes to IDLE. While fault=1, WALK is never granted. Only reset clears fault and overrun.
- Requests:
  - ped_button high in IDLE, CLEAR or HOLD sets request_pending; the request is served at the next red entry.
  - ped_button in WALK is ignored, since that request is already being served.
  - A button press in the same cycle as a grant from IDLE is absorbed by the grant: request_pending stays 0.
- A tick in the same cycle as red_entry is not counted toward the new phase.

Optional Feature:
- Macro: PED_COUNTDOWN_EN.
- Defined:
  - The countdown port exists.
  - In CLEAR it shows the counter value (CLEAR_TICKS down to 1).
  - In all other states it shows 0.
  - It is registered with the same timing as the lamp outputs.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ped_pkg holds:
  - light code localparams LIGHT_RED, LIGHT_GREEN, LIGHT_YELLOW, LIGHT_ILLEGAL;
  - the state enum IDLE/WALK/CLEAR/HOLD as a 2-bit typedef.
- The traffic light block imports the same light codes from ped_pkg.
- One sub-module, ped_phase_counter: an 8-bit loadable down-counter with tick enable and an expire flag (counter==1 && tick).

Test Plan:
- Reset mid-WALK (reset_n low for 1 cycle) -> walk=0, dont_walk=1, request_pending=0 immediately (async). No grant from the red that is still present.
- Button pulse during green, then light->red, WALK_TICKS=4, CLEAR_TICKS=3 -> walk=1 the cycle after red_entry for exactly 4 ticks; then dont_walk toggles 1,0,1 over 3 ticks; then HOLD with dont_walk=1; request_pending=0.
- Red entry with no request, RECALL=0 -> walk never asserts; FSM passes through HOLD and returns to IDLE when light goes green.
- Light goes red->green on the 2nd tick of WALK -> walk=0 and dont_walk=1 on the next edge; overrun=1 and stays 1 across later cycles.
- light=2'b00 for one cycle during IDLE, then a button press and red entry -> fault=1; walk stays 0 indefinitely.
- PED_COUNTDOWN_EN defined, CLEAR_TICKS=3 -> countdown reads 3,2,1 across the CLEAR ticks, then 0 in HOLD.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian signal controller.
//   - Vehicle light codes as driven by the intersection light state machine.
//   - Pedestrian head state encoding (2-bit enum).
// Optional build macro used by the files importing this package: PED_COUNTDOWN_EN.
package ped_pkg;

  localparam logic [1:0] LIGHT_ILLEGAL = 2'b00;
  localparam logic [1:0] LIGHT_RED     = 2'b01;
  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WALK  = 2'b01,
    CLEAR = 2'b10,
    HOLD  = 2'b11
  } ped_state_e;

endpackage

// File: rtl/ped_phase_counter.sv
// ped_phase_counter: 8-bit loadable down-counter timing the WALK and CLEAR phases.
// Ports:
//   clock, reset_n  - rising-edge clock, asynchronous active-low reset
//   load            - load load_value (has priority over tick)
//   load_value      - value loaded on load
//   tick            - decrement enable (saturates at zero)
//   expire          - tick arriving while the count is 1 (last tick of a phase)
//   count_next      - value the counter takes at the next edge (PED_COUNTDOWN_EN only)
module ped_phase_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       tick,
  output logic       expire
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [7:0] count_next
`endif
);

  logic [7:0] count_r;
  logic [7:0] count_nxt_s;

  // Next count: load wins, otherwise decrement on tick without wrapping below zero.
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_value;
    end else if (tick && (count_r != 8'd0)) begin
      count_nxt_s = count_r - 8'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Expiry flag for the phase currently being timed.
  always_comb begin
    expire = tick && (count_r == 8'd1);
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

`ifdef PED_COUNTDOWN_EN
  assign count_next = count_nxt_s;
`endif

endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK / DON'T WALK head for the crossing parallel to red.
// Latches button requests, grants a timed WALK then a flashing clearance on red entry,
// and aborts safely if red ends early or an illegal light code appears.
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   tick             - single-cycle timebase enable
//   light            - vehicle light code (red/green/yellow, 2'b00 illegal)
//   ped_button       - synchronised, debounced push button (level)
//   walk, dont_walk  - lamp drives (dont_walk blinks in clearance)
//   request_pending  - request latched, not yet served
//   overrun          - sticky: red ended during WALK/CLEAR
//   fault            - sticky: illegal light code seen
//   countdown        - remaining clearance ticks (only when PED_COUNTDOWN_EN is defined)
// Optional feature macro: PED_COUNTDOWN_EN.
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned WALK_TICKS  = 8,
  parameter int unsigned CLEAR_TICKS = 6,
  parameter int unsigned RECALL      = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [1:0] light,
  input  logic       ped_button,
  output logic       walk,
  output logic       dont_walk,
  output logic       request_pending,
  output logic       overrun,
  output logic       fault
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [7:0] countdown
`endif
);

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_TICKS);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_TICKS);

  ped_state_e state_r, state_nxt_s;
  logic [1:0] prev_light_r;
  logic       flash_r, flash_nxt_s;
  logic       request_pending_r, req_nxt_s;
  logic       overrun_r, overrun_nxt_s;
  logic       fault_r, fault_nxt_s;
  logic       walk_r, walk_nxt_s;
  logic       dont_walk_r, dont_walk_nxt_s;
  logic       is_red_s, red_entry_s, dec_s, load_s, expire_s;
  logic [7:0] load_val_s;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] cnt_next_s;
  logic [7:0] countdown_r, countdown_nxt_s;
`endif

  // Red detection; the counter only runs while a timed phase is active under red.
  always_comb begin
    is_red_s    = (light == LIGHT_RED);
    red_entry_s = is_red_s && (prev_light_r != LIGHT_RED);
    dec_s       = tick && is_red_s && ((state_r == WALK) || (state_r == CLEAR));
  end

  ped_phase_counter u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_s),
    .load_value (load_val_s),
    .tick       (dec_s),
    .expire     (expire_s)
`ifdef PED_COUNTDOWN_EN
    ,
    .count_next (cnt_next_s)
`endif
  );

  // Next-state logic: phase sequencing, abort, fault and request latching.
  always_comb begin
    state_nxt_s   = state_r;
    flash_nxt_s   = flash_r;
    overrun_nxt_s = overrun_r;
    fault_nxt_s   = fault_r;
    load_s        = 1'b0;
    load_val_s    = WALK_LOAD;
    // Button is ignored in WALK: that request is the one being served.
    req_nxt_s     = request_pending_r | (ped_button & (state_r != WALK));
    case (state_r)
      IDLE: begin
        if (red_entry_s && (request_pending_r || (RECALL != 32'd0)) && !fault_r) begin
          // Grant absorbs a same-cycle press; the load also swallows a same-cycle tick.
          state_nxt_s = WALK;
          load_s      = 1'b1;
          load_val_s  = WALK_LOAD;
          req_nxt_s   = 1'b0;
        end else if (red_entry_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WALK: begin
        if (!is_red_s) begin
          state_nxt_s   = IDLE;
          overrun_nxt_s = 1'b1;
        end else if (expire_s) begin
          state_nxt_s = CLEAR;
          load_s      = 1'b1;
          load_val_s  = CLEAR_LOAD;
          flash_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WALK;
        end
      end
      CLEAR: begin
        if (!is_red_s) begin
          state_nxt_s   = IDLE;
          overrun_nxt_s = 1'b1;
        end else if (tick) begin
          flash_nxt_s = ~flash_r;
          state_nxt_s = expire_s ? HOLD : CLEAR;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      HOLD: begin
        if (!is_red_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Illegal code overrides everything; in WALK/CLEAR the abort above also flags overrun.
    if (light == LIGHT_ILLEGAL) begin
      fault_nxt_s = 1'b1;
      state_nxt_s = IDLE;
    end else begin
      fault_nxt_s = fault_r;
    end
  end

  // Lamp and countdown values for the state being entered.
  always_comb begin
    walk_nxt_s = (state_nxt_s == WALK);
    if (state_nxt_s == CLEAR) begin
      dont_walk_nxt_s = flash_nxt_s;
    end else begin
      dont_walk_nxt_s = (state_nxt_s != WALK);
    end
`ifdef PED_COUNTDOWN_EN
    if (state_nxt_s == CLEAR) begin
      countdown_nxt_s = cnt_next_s;
    end else begin
      countdown_nxt_s = 8'd0;
    end
`endif
  end

  // State, history and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      prev_light_r      <= LIGHT_RED;
      flash_r           <= 1'b1;
      request_pending_r <= 1'b0;
      overrun_r         <= 1'b0;
      fault_r           <= 1'b0;
      walk_r            <= 1'b0;
      dont_walk_r       <= 1'b1;
`ifdef PED_COUNTDOWN_EN
      countdown_r       <= 8'd0;
`endif
    end else begin
      state_r           <= state_nxt_s;
      prev_light_r      <= light;
      flash_r           <= flash_nxt_s;
      request_pending_r <= req_nxt_s;
      overrun_r         <= overrun_nxt_s;
      fault_r           <= fault_nxt_s;
      walk_r            <= walk_nxt_s;
      dont_walk_r       <= dont_walk_nxt_s;
`ifdef PED_COUNTDOWN_EN
      countdown_r       <= countdown_nxt_s;
`endif
    end
  end

  assign walk            = walk_r;
  assign dont_walk       = dont_walk_r;
  assign request_pending = request_pending_r;
  assign overrun         = overrun_r;
  assign fault           = fault_r;
`ifdef PED_COUNTDOWN_EN
  assign countdown       = countdown_r;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with WALK_TICKS=4, CLEAR_TICKS=3, RECALL=0.
// Each step drives inputs on the falling edge, queues the expected lamp/flag vector
// {walk, dont_walk, request_pending, overrun, fault} (and countdown when
// PED_COUNTDOWN_EN is defined), then pops and compares it 1 ns after the rising edge.
module tb_ped_signal_ctrl;

  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] Y = 2'b11;
  localparam logic [1:0] X = 2'b00;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick = 1'b0;
  logic [1:0] light = 2'b01;
  logic       ped_button = 1'b0;
  logic       walk, dont_walk, request_pending, overrun, fault;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] v;
    logic [7:0] cd;
  } exp_t;

  exp_t sb_q[$];

  ped_signal_ctrl #(
    .WALK_TICKS  (4),
    .CLEAR_TICKS (3),
    .RECALL      (0)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .tick            (tick),
    .light           (light),
    .ped_button      (ped_button),
    .walk            (walk),
    .dont_walk       (dont_walk),
    .request_pending (request_pending),
    .overrun         (overrun),
    .fault           (fault)
`ifdef PED_COUNTDOWN_EN
    ,
    .countdown       (countdown)
`endif
  );

  always #5 clock = ~clock;

  task automatic push_exp(input string tag, input logic [4:0] ev, input logic [7:0] cd);
    exp_t e;
    e.tag = tag;
    e.v   = ev;
    e.cd  = cd;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t       e;
    logic [4:0] obs;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
    end else begin
      e   = sb_q.pop_front();
      obs = {walk, dont_walk, request_pending, overrun, fault};
      assert (obs === e.v) else begin
        n_errors++;
        $error("FAIL %s: observed %b expected %b (walk,dont_walk,req,overrun,fault)",
               e.tag, obs, e.v);
      end
`ifdef PED_COUNTDOWN_EN
      n_checks++;
      assert (countdown === e.cd) else begin
        n_errors++;
        $error("FAIL %s_countdown: observed %0d expected %0d", e.tag, countdown, e.cd);
      end
`endif
    end
  endtask

  task automatic step(input string tag, input logic tk, input logic [1:0] lt,
                      input logic btn, input logic [4:0] ev, input logic [7:0] cd);
    @(negedge clock);
    tick       = tk;
    light      = lt;
    ped_button = btn;
    push_exp(tag, ev, cd);
    @(posedge clock);
    #1;
    pop_check();
  endtask

  initial begin
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    push_exp("reset_state", 5'b01000, 8'd0);
    pop_check();
    reset_n = 1'b1;

    // Red present at reset release is not a red entry.
    step("rel_red",      1'b0, R, 1'b0, 5'b01000, 8'd0);
    step("rel_red_tick", 1'b1, R, 1'b0, 5'b01000, 8'd0);

    // Request during green, grant on red entry; tick and press in the grant cycle are absorbed.
    step("btn_green",    1'b0, G, 1'b1, 5'b01100, 8'd0);
    step("green_wait",   1'b0, G, 1'b0, 5'b01100, 8'd0);
    step("grant",        1'b1, R, 1'b1, 5'b10000, 8'd0);
    step("walk_t1",      1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk_btn",     1'b0, R, 1'b1, 5'b10000, 8'd0);
    step("walk_t2",      1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk_t3",      1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk_t4",      1'b1, R, 1'b0, 5'b01000, 8'd3);
    step("clr_t1",       1'b1, R, 1'b0, 5'b00000, 8'd2);
    step("clr_notick",   1'b0, R, 1'b0, 5'b00000, 8'd2);
    step("clr_t2",       1'b1, R, 1'b0, 5'b01000, 8'd1);
    step("clr_t3",       1'b1, R, 1'b0, 5'b01000, 8'd0);
    step("hold",         1'b1, R, 1'b0, 5'b01000, 8'd0);

    // Red entry without a request: no WALK, back to idle on green.
    step("hold_exit",    1'b0, G, 1'b0, 5'b01000, 8'd0);
    step("norq_red",     1'b0, R, 1'b0, 5'b01000, 8'd0);
    step("norq_t1",      1'b1, R, 1'b0, 5'b01000, 8'd0);
    step("norq_t2",      1'b1, R, 1'b0, 5'b01000, 8'd0);
    step("norq_t3",      1'b1, R, 1'b0, 5'b01000, 8'd0);
    step("norq_green",   1'b0, G, 1'b0, 5'b01000, 8'd0);

    // Red ends on the 2nd WALK tick: abort, sticky overrun.
    step("btn2",         1'b0, G, 1'b1, 5'b01100, 8'd0);
    step("grant2",       1'b0, R, 1'b0, 5'b10000, 8'd0);
    step("walk2_t1",     1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("abort_t2",     1'b1, G, 1'b0, 5'b01010, 8'd0);
    step("ovr_sticky1",  1'b1, G, 1'b0, 5'b01010, 8'd0);
    step("ovr_sticky2",  1'b0, Y, 1'b0, 5'b01010, 8'd0);

    // Asynchronous reset in the middle of WALK.
    step("btn3",         1'b0, G, 1'b1, 5'b01110, 8'd0);
    step("grant3",       1'b0, R, 1'b0, 5'b10010, 8'd0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    push_exp("async_rst", 5'b01000, 8'd0);
    pop_check();
    @(negedge clock);
    reset_n = 1'b1;
    step("no_regrant",   1'b1, R, 1'b0, 5'b01000, 8'd0);
    step("no_regrant2",  1'b0, R, 1'b0, 5'b01000, 8'd0);

    // Full WALK then abort on the final clearance tick: abort beats expiry.
    step("btn_red",      1'b0, R, 1'b1, 5'b01100, 8'd0);
    step("green4",       1'b0, G, 1'b0, 5'b01100, 8'd0);
    step("grant4",       1'b0, R, 1'b0, 5'b10000, 8'd0);
    step("walk4_t1",     1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk4_t2",     1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk4_t3",     1'b1, R, 1'b0, 5'b10000, 8'd0);
    step("walk4_t4",     1'b1, R, 1'b0, 5'b01000, 8'd3);
    step("clr4_t1",      1'b1, R, 1'b0, 5'b00000, 8'd2);
    step("clr4_t2",      1'b1, R, 1'b0, 5'b01000, 8'd1);
    step("abort_expire", 1'b1, G, 1'b0, 5'b01010, 8'd0);

    // Illegal code: fault is sticky and blocks every later grant.
    step("illegal",      1'b0, X, 1'b0, 5'b01011, 8'd0);
    step("btn_flt",      1'b0, G, 1'b1, 5'b01111, 8'd0);
    step("flt_red",      1'b0, R, 1'b0, 5'b01111, 8'd0);
    step("flt_t1",       1'b1, R, 1'b0, 5'b01111, 8'd0);
    step("flt_t2",       1'b1, R, 1'b0, 5'b01111, 8'd0);
    step("flt_t3",       1'b1, R, 1'b0, 5'b01111, 8'd0);
    step("flt_green",    1'b0, G, 1'b0, 5'b01111, 8'd0);
    step("flt_red2",     1'b0, R, 1'b0, 5'b01111, 8'd0);
    step("flt_red2_t",   1'b1, R, 1'b0, 5'b01111, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
